// File: rtl/uart_boot_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_boot_loader_if
// Purpose  : UART byte stream in, instruction-memory word write port out.
// Revision : 1.0
// ============================================================================
interface uart_boot_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  // master: byte source / memory sink (receiver + CPU side); slave: the loader
  modport master (
    output rx_valid,
    output rx_data,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/uart_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_boot_loader
// Purpose  : Parses a framed boot image from the UART byte stream, writes it
//            word-wise to instruction memory and releases CPU reset on success.
// Revision : 1.0
// ============================================================================
module uart_boot_loader #(
  parameter int         MAX_BYTES      = 1024,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  uart_boot_loader_if.slave bus,
  output logic              cpu_reset_n,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       byte_count
);

  localparam int                 TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]        MAX_LEN    = 17'(MAX_BYTES);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CHECK  = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        len_q, len_d;
  logic [15:0]        byte_count_q, byte_count_d;
  logic [7:0]         csum_q, csum_d;
  logic [23:0]        word_q, word_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               mem_we_q, mem_we_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic               cpu_reset_n_q, cpu_reset_n_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;

  logic [15:0]        rx_len;
  logic               len_bad;
  logic               in_frame;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    byte_count_d = byte_count_q;
    csum_d       = csum_q;
    word_d       = word_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    rx_len   = {bus.rx_data, len_q[7:0]};
    len_bad  = (rx_len == 16'd0) || (rx_len[1:0] != 2'b00) || ({1'b0, rx_len} > MAX_LEN);
    in_frame = state_q inside {LEN_LO, LEN_HI, DATA, CHECK};

    case (state_q)
      IDLE, ERROR: begin
        if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
          state_d      = LEN_LO;
          byte_count_d = 16'd0;
          csum_d       = 8'd0;
          word_d       = 24'd0;
        end
      end
      LEN_LO: begin
        if (bus.rx_valid) begin
          len_d   = {8'h00, bus.rx_data};
          state_d = LEN_HI;
        end
      end
      LEN_HI: begin
        if (bus.rx_valid) begin
          len_d   = rx_len;
          state_d = len_bad ? ERROR : DATA;
        end
      end
      DATA: begin
        if (bus.rx_valid) begin
          csum_d       = csum_q + bus.rx_data;
          byte_count_d = byte_count_q + 16'd1;
          // Lanes 0..2 are buffered; lane 3 completes the word straight from rx_data.
          case (byte_count_q[1:0])
            2'd0: word_d[7:0]   = bus.rx_data;
            2'd1: word_d[15:8]  = bus.rx_data;
            2'd2: word_d[23:16] = bus.rx_data;
            default: begin
              mem_we_d    = 1'b1;
              mem_addr_d  = {16'd0, byte_count_q[15:2], 2'b00};
              mem_wdata_d = {bus.rx_data, word_q};
            end
          endcase
          if (byte_count_q == (len_q - 16'd1)) begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (bus.rx_valid) begin
          state_d = (bus.rx_data == csum_q) ? DONE : ERROR;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (in_frame && !bus.rx_valid && (timer_q == TIMER_LAST)) begin
      state_d = ERROR;
    end

    // Idle-gap counter restarts on every byte and on every state change.
    if (in_frame && !bus.rx_valid && (state_d == state_q)) begin
      timer_d = timer_q + TIMER_W'(1);
    end else begin
      timer_d = '0;
    end

    cpu_reset_n_d = (state_d == DONE);
    done_d        = (state_d == DONE);
    error_d       = (state_d == ERROR);
    busy_d        = state_d inside {LEN_LO, LEN_HI, DATA, CHECK};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      len_q         <= 16'd0;
      byte_count_q  <= 16'd0;
      csum_q        <= 8'd0;
      word_q        <= 24'd0;
      timer_q       <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 32'd0;
      mem_wdata_q   <= 32'd0;
      cpu_reset_n_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      byte_count_q  <= byte_count_d;
      csum_q        <= csum_d;
      word_q        <= word_d;
      timer_q       <= timer_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      cpu_reset_n_q <= cpu_reset_n_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_reset_n   = cpu_reset_n_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign byte_count    = byte_count_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_boot_loader
// Purpose  : Frame-level scoreboard bench for uart_boot_loader.
// Revision : 1.0
// ============================================================================
module tb_uart_boot_loader;

  localparam int         MAX_BYTES = 1024;
  localparam int         TIMEOUT   = 50;
  localparam logic [7:0] SYNC      = 8'hA5;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_reset_n;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] byte_count;

  int          n_tests   = 0;
  int          n_fail    = 0;
  int          n_we_seen = 0;
  int          n_we_exp  = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  bit          m_done    = 1'b0;
  logic [15:0] m_bc      = 16'd0;

  uart_boot_loader_if bus ();

  uart_boot_loader #(
    .MAX_BYTES      (MAX_BYTES),
    .TIMEOUT_CYCLES (TIMEOUT),
    .SYNC_BYTE      (SYNC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .cpu_reset_n (cpu_reset_n),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .byte_count  (byte_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_flags(input string tag, input bit e_busy, input bit e_done, input bit e_err);
    check_eq({tag, "_busy"},  32'(busy),        32'(e_busy));
    check_eq({tag, "_done"},  32'(done),        32'(e_done));
    check_eq({tag, "_error"}, 32'(error),       32'(e_err));
    check_eq({tag, "_cpurn"}, 32'(cpu_reset_n), 32'(e_done));
  endtask

  // Every observed write is matched in order against the expected write list.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      n_we_seen++;
      if (exp_addr_q.size() > 0) begin
        check_eq("wr_addr", bus.mem_addr, exp_addr_q.pop_front());
        check_eq("wr_data", bus.mem_wdata, exp_data_q.pop_front());
      end
    end
  end

  function automatic int rg(input int m);
    return (m == 0) ? 0 : int'($urandom_range(0, m));
  endfunction

  task automatic put_byte(input logic [7:0] b, input int gap);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset();
    bus.rx_valid = 1'b0;
    reset        = 1'b1;
    @(negedge clk);
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    check_eq("rst_we",    32'(bus.mem_we),   32'd0);
    check_eq("rst_addr",  bus.mem_addr,      32'd0);
    check_eq("rst_wdata", bus.mem_wdata,     32'd0);
    check_eq("rst_bc",    32'(byte_count),   32'd0);
    reset = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    n_we_seen = 0;
    n_we_exp  = 0;
    m_done    = 1'b0;
    m_bc      = 16'd0;
  endtask

  // Sends SYNC, length, n_send payload bytes and (for a complete valid frame or
  // a locked loader) the checksum; predicts writes and status from the frame.
  task automatic send_frame(input logic [15:0] len, input logic [7:0] pay[$],
                            input logic [7:0] cks, input int n_send, input int max_gap);
    int l      = int'(len);
    int sum    = 0;
    bit len_ok = (l != 0) && (l % 4 == 0) && (l <= MAX_BYTES);
    bit locked = m_done;

    if (!locked && len_ok) begin
      for (int w = 0; w + 3 < n_send; w += 4) begin
        exp_addr_q.push_back(32'(w));
        exp_data_q.push_back({pay[w+3], pay[w+2], pay[w+1], pay[w]});
        n_we_exp++;
      end
      for (int i = 0; i < n_send; i++) sum += int'(pay[i]);
    end

    put_byte(SYNC, rg(max_gap));
    if (!locked) begin
      check_flags("sync", 1'b1, 1'b0, 1'b0);
      check_eq("sync_bc", 32'(byte_count), 32'd0);
    end
    put_byte(len[7:0], rg(max_gap));
    put_byte(len[15:8], rg(max_gap));
    if (!locked && !len_ok) check_flags("badlen", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < n_send; i++) put_byte(pay[i], (i == n_send - 1) ? 0 : rg(max_gap));

    if (locked) begin
      put_byte(cks, 0);
      check_flags("locked", 1'b0, 1'b1, 1'b0);
      check_eq("locked_bc", 32'(byte_count), 32'(m_bc));
    end else if (!len_ok) begin
      check_flags("badlen_tail", 1'b0, 1'b0, 1'b1);
      check_eq("badlen_bc", 32'(byte_count), 32'd0);
    end else if (n_send == l) begin
      check_flags("last_data", 1'b1, 1'b0, 1'b0);
      check_eq("last_bc", 32'(byte_count), 32'(len));
      put_byte(cks, 0);
      if (cks == 8'(sum % 256)) begin
        check_flags("cks_ok", 1'b0, 1'b1, 1'b0);
        m_done = 1'b1;
        m_bc   = len;
      end else begin
        check_flags("cks_bad", 1'b0, 1'b0, 1'b1);
      end
      check_eq("final_bc", 32'(byte_count), 32'(len));
    end
    @(negedge clk);
    check_eq("write_count", 32'(n_we_seen), 32'(n_we_exp));
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0]  pay[$];
    logic [7:0]  good[$];
    logic [15:0] len;
    logic [7:0]  cks;
    int          sum;
    int          kind;

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    good = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};

    // Good frame, then a locked loader ignoring another SYNC-led frame
    do_reset();
    send_frame(16'd8, good, 8'h82, 8, 0);
    send_frame(16'd8, good, 8'h82, 8, 0);

    // Bad checksum, then the good frame recovers
    do_reset();
    send_frame(16'd8, good, 8'h83, 8, 0);
    send_frame(16'd8, good, 8'h82, 8, 1);

    // Bad lengths: not a multiple of 4, and larger than MAX_BYTES
    do_reset();
    pay = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    send_frame(16'h0006, pay, 8'h00, 6, 0);
    pay = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(16'h0804, pay, 8'h00, 4, 0);

    // Timeout mid-word, then a fresh frame
    do_reset();
    put_byte(SYNC, 0);
    put_byte(8'h04, 0);
    put_byte(8'h00, 0);
    put_byte(8'h11, 0);
    repeat (TIMEOUT - 1) @(negedge clk);
    check_flags("pre_timeout", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check_flags("timeout", 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    check_eq("timeout_writes", 32'(n_we_seen), 32'(n_we_exp));
    send_frame(16'd8, good, 8'h82, 8, 0);

    // Maximum-length image, bytes on consecutive cycles, then locked
    do_reset();
    pay.delete();
    for (int i = 0; i < MAX_BYTES; i++) pay.push_back(8'(i));
    sum = 0;
    for (int i = 0; i < MAX_BYTES; i++) sum += int'(pay[i]);
    send_frame(16'(MAX_BYTES), pay, 8'(sum % 256), MAX_BYTES, 0);
    send_frame(16'd8, good, 8'h82, 8, 0);

    // Reset during DATA after 6 payload bytes, then a fresh frame
    do_reset();
    send_frame(16'd8, good, 8'h82, 6, 1);
    do_reset();
    send_frame(16'd8, good, 8'h82, 8, 0);

    // Randomized frame sequences
    for (int it = 0; it < 25; it++) begin
      do_reset();
      for (int f = 0; f < int'($urandom_range(1, 3)); f++) begin
        kind = int'($urandom_range(0, 3));
        len  = 16'(4 * $urandom_range(1, 16));
        pay.delete();
        for (int i = 0; i < int'(len); i++) pay.push_back(8'($urandom));
        sum = 0;
        for (int i = 0; i < int'(len); i++) sum += int'(pay[i]);
        cks = 8'(sum % 256);
        if (kind == 1) cks = 8'((sum + 1 + int'($urandom_range(0, 254))) % 256);
        if (kind == 2) begin
          case ($urandom_range(0, 2))
            0:       len = 16'd0;
            1:       len = len + 16'($urandom_range(1, 3));
            default: len = 16'(MAX_BYTES + 4 * $urandom_range(1, 100));
          endcase
          for (int i = 0; i < pay.size(); i++) if (pay[i] == SYNC) pay[i] = 8'h5A;
        end
        send_frame(len, pay, cks, pay.size(), 3);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_boot_loader.md
# uart_boot_loader

Sequences program loading for the UART-booted CPU. Consumes the received byte stream (one-cycle valid strobes from the UART receiver), parses a framed image (sync, length, payload, checksum), and packs payload bytes little-endian into 32-bit words for the CPU instruction memory write port. Holds the CPU in reset until a complete, checksum-valid image is loaded, then releases it. Sits between the UART receiver and the CPU's write/reset inputs.

## Interface
- MAX_BYTES, 1024, largest accepted payload length in bytes (multiple of 4)
- TIMEOUT_CYCLES, 1000000, idle cycles between bytes before a frame in progress is aborted
- SYNC_BYTE, 8'hA5, frame start marker

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_valid  in  1  one-cycle strobe, rx_data is valid
- rx_data  in  8  received byte
- mem_we  out  1  one-cycle instruction-memory word write strobe
- mem_addr  out  32  byte address of written word (word aligned)
- mem_wdata  out  32  assembled word
- cpu_reset_n  out  1  active-low CPU reset; low until image accepted
- busy  out  1  frame in progress (LEN_LO..CHECK)
- done  out  1  image accepted, sticky until reset
- error  out  1  last frame failed; cleared by next SYNC_BYTE or reset
- byte_count  out  16  payload bytes received in current frame

## Operation
- States: IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR.
- IDLE: bytes other than SYNC_BYTE ignored; SYNC_BYTE -> LEN_LO, clears byte_count, checksum, error.
- LEN_LO: byte = length[7:0] -> LEN_HI. LEN_HI: byte = length[15:8]; length 0, not multiple of 4, or > MAX_BYTES -> ERROR; else -> DATA.
- DATA: each byte added to 8-bit checksum (sum mod 256) and placed in lane byte_count[1:0] (lane 0 = bits 7:0); byte_count increments. On 4th byte of a word: mem_we pulse, mem_wdata = assembled word, mem_addr = {byte_count[15:2], 2'b00} of that word (first word at 0). After byte length-1 -> CHECK.
- CHECK: byte equal to checksum -> DONE; else -> ERROR.
- DONE: cpu_reset_n = 1, done = 1; all further bytes ignored (including SYNC_BYTE) until reset.
- ERROR: error = 1, cpu_reset_n = 0; SYNC_BYTE restarts as in IDLE. Memory already written is not cleared; a later good frame overwrites it.
- Timeout: counter cleared on every rx_valid and on state entry; in LEN_LO/LEN_HI/DATA/CHECK reaching TIMEOUT_CYCLES -> ERROR.
- SYNC_BYTE inside LEN/DATA/CHECK is data, not a restart.
- Length is in bytes, 16 bit; byte_count and address arithmetic 16 bit, zero-extended to 32.

## Timing
- Reset values: mem_we 0, mem_addr 0, mem_wdata 0, cpu_reset_n 0, busy 0, done 0, error 0, byte_count 0, state IDLE, timeout counter 0.
- All outputs registered. State changes the cycle after the accepting rx_valid.
- mem_we high exactly one cycle, the cycle after the rx_valid carrying a word's 4th byte; mem_addr/mem_wdata valid in that cycle and held until next write.
- rx_valid may assert every cycle; no byte may be dropped; no backpressure.
- done and cpu_reset_n rise the cycle after the matching checksum byte; error rises the cycle after the failing byte or timeout expiry.
- reset mid-frame: all state returns to reset values next edge, any pending partial word discarded, no mem_we generated.

## Test plan
- Good frame: A5 08 00, 13 00 00 00 6F 00 00 00, checksum 0x82 -> mem_we twice: addr 0 data 0x00000013, addr 4 data 0x0000006F; done=1, cpu_reset_n=1 one cycle after checksum; busy back to 0.
- Bad checksum: same frame with checksum 0x83 -> both writes occur, error=1, done=0, cpu_reset_n stays 0; then re-send good frame -> error clears on A5, done=1.
- Bad length: A5 06 00 and A5 04 08 (2052 > 1024) -> error=1 after length MSB, no mem_we, subsequent payload bytes ignored until A5.
- Timeout: A5 04 00 11 then silence TIMEOUT_CYCLES (bench overrides to 50) -> error=1 at cycle 50, no mem_we; partial word discarded.
- Back-to-back bytes on consecutive cycles, length 1024, incrementing payload -> 256 writes, addresses 0..0x3FC, data matches, no loss; byte after done (A5) ignored.
- Reset asserted during DATA after 6 payload bytes -> all outputs at reset values next cycle, no further mem_we; fresh frame loads correctly.
